// File: rtl/exc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : exc_arbiter
// Purpose  : Serialises three exception/interrupt sources into CP0. Raw
//            sources are synchronised and edge-detected into a pending
//            register. One masked, highest-index-first winner is presented
//            on exp_req until CP0 acknowledges, then tracked as in service
//            until ERET retires it. An unacknowledged request is abandoned
//            after REQ_TIMEOUT cycles and flagged in timeout_err.
// Options  : define EXC_ARBITER_NESTED_EN to let a higher-index source
//            preempt the source in service (2-entry in-service stack).
// Revision : 1.0  initial release
// ============================================================================
module exc_arbiter #(
   parameter int SYNC_STAGES = 2,   // 1..3
   parameter int REQ_TIMEOUT = 15   // 1..15
) (
   input  logic       clk,
   input  logic       reset,        // asynchronous, active low
   input  logic [2:0] irq_in,
   input  logic [2:0] mask,
   input  logic       exp_ack,
   input  logic       eret,
   input  logic       err_clr,
   output logic [2:0] exp_req,
   output logic [2:0] pending,
   output logic [2:0] in_service,
   output logic [1:0] cause_id,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      SERVE = 2'd2
   } state_t;

   state_t     state;
   logic [2:0] sync_q [SYNC_STAGES];
   logic [2:0] prev_q;
   logic [2:0] edge_det;
   logic [1:0] cur;          // index of the source being requested/served
   logic [3:0] cnt;          // REQ cycles without acknowledge
   logic [2:0] eligible;
   logic       any_elig;
   logic [1:0] win;
   logic       grant;        // IDLE -> REQ this cycle
   logic       preempt;      // SERVE -> REQ for a higher source this cycle
   logic       timeout_fire;
   logic [2:0] grant_clr;
   logic [2:0] restore;

`ifdef EXC_ARBITER_NESTED_EN
   logic [1:0] stack_q [2];
   logic [1:0] sp;           // number of stacked (preempted) sources
   logic [1:0] top;
   assign top = (sp == 2'd2) ? stack_q[1] : stack_q[0];
`endif

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      case (idx)
         2'd0:    onehot = 3'b001;
         2'd1:    onehot = 3'b010;
         2'd2:    onehot = 3'b100;
         default: onehot = 3'b000;
      endcase
   endfunction

   // Synchroniser chain plus previous-value register for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign eligible = pending & mask;
   assign any_elig = |eligible;
   assign busy     = (state != IDLE);

   // Fixed priority pick, highest index wins
   always_comb begin
      win = 2'd0;
      if (eligible[2])      win = 2'd2;
      else if (eligible[1]) win = 2'd1;
   end

   // Per-cycle decisions shared by the pending register and the FSM
   always_comb begin
      grant        = 1'b0;
      preempt      = 1'b0;
      timeout_fire = 1'b0;
      case (state)
         IDLE:    grant        = any_elig;
         REQ:     timeout_fire = !exp_ack && (cnt == 4'(REQ_TIMEOUT - 1));
`ifdef EXC_ARBITER_NESTED_EN
         // ERET retires the current service first; a waiting source then wins normally
         SERVE:   preempt      = !eret && any_elig && (win > cur) && (sp != 2'd2);
`endif
         default: ;
      endcase
      grant_clr = (grant || preempt) ? onehot(win) : 3'b000;
      restore   = timeout_fire ? onehot(cur) : 3'b000;
   end

   // Arbitration FSM with registered outputs; a new edge beats the grant clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cur         <= 2'd0;
         cnt         <= 4'd0;
         pending     <= 3'b000;
         exp_req     <= 3'b000;
         in_service  <= 3'b000;
         cause_id    <= 2'd0;
         timeout_err <= 1'b0;
`ifdef EXC_ARBITER_NESTED_EN
         sp          <= 2'd0;
         stack_q[0]  <= 2'd0;
         stack_q[1]  <= 2'd0;
`endif
      end else begin
         pending <= (pending & ~grant_clr) | edge_det | restore;

         if (timeout_fire)  timeout_err <= 1'b1;
         else if (err_clr)  timeout_err <= 1'b0;

         case (state)
            IDLE: begin
               if (grant) begin
                  state    <= REQ;
                  cur      <= win;
                  exp_req  <= onehot(win);
                  cause_id <= win + 2'd1;
                  cnt      <= 4'd0;
               end
            end
            REQ: begin
               if (exp_ack) begin
                  state      <= SERVE;
                  exp_req    <= 3'b000;
                  in_service <= onehot(cur);
                  cnt        <= 4'd0;
               end else if (timeout_fire) begin
                  exp_req <= 3'b000;
                  cnt     <= 4'd0;
`ifdef EXC_ARBITER_NESTED_EN
                  if (sp != 2'd0) begin
                     // Abandoned preemption: resume the interrupted service
                     state    <= SERVE;
                     cur      <= top;
                     cause_id <= top + 2'd1;
                     sp       <= sp - 2'd1;
                  end else
`endif
                  begin
                     state    <= IDLE;
                     cause_id <= 2'd0;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            SERVE: begin
`ifdef EXC_ARBITER_NESTED_EN
               if (preempt) begin
                  stack_q[sp[0]] <= cur;
                  sp             <= sp + 2'd1;
                  state          <= REQ;
                  cur            <= win;
                  exp_req        <= onehot(win);
                  cause_id       <= win + 2'd1;
                  cnt            <= 4'd0;
               end else
`endif
               if (eret) begin
`ifdef EXC_ARBITER_NESTED_EN
                  if (sp != 2'd0) begin
                     cur        <= top;
                     cause_id   <= top + 2'd1;
                     in_service <= onehot(top);
                     sp         <= sp - 2'd1;
                  end else
`endif
                  begin
                     state      <= IDLE;
                     in_service <= 3'b000;
                     cause_id   <= 2'd0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exc_arbiter.sv
`timescale 1ns/1ps
module tb_exc_arbiter;

   localparam int S  = 2;
   localparam int TO = 15;
   localparam int M_IDLE  = 0;
   localparam int M_REQ   = 1;
   localparam int M_SERVE = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] irq_in = 3'b000;
   logic [2:0] mask = 3'b111;
   logic       exp_ack = 1'b0;
   logic       eret = 1'b0;
   logic       err_clr = 1'b0;
   logic [2:0] exp_req, pending, in_service;
   logic [1:0] cause_id;
   logic       busy, timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   exc_arbiter #(.SYNC_STAGES(S), .REQ_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .mask(mask),
      .exp_ack(exp_ack), .eret(eret), .err_clr(err_clr),
      .exp_req(exp_req), .pending(pending), .in_service(in_service),
      .cause_id(cause_id), .busy(busy), .timeout_err(timeout_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int         m_mode;
   int         m_w;
   int         m_cnt;
   bit [2:0]   m_pend;
   bit         m_err;
   int         m_stk[$];
   bit [2:0]   m_hist[6];   // m_hist[k] = irq_in sampled k edges ago

   function automatic bit [2:0] oh(input int i);
      bit [2:0] v = 3'b000;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int top_of(input bit [2:0] v);
      for (int i = 2; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_w = 0; m_cnt = 0; m_pend = 3'b000; m_err = 1'b0;
      m_stk.delete();
      for (int k = 0; k < 6; k++) m_hist[k] = 3'b000;
   endtask

   task automatic model_step();
      bit [2:0] elig, edg;
      int       t;
      bit       tmo;
      tmo = 1'b0;
      for (int k = 5; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = irq_in;
      // irq first high at edge n becomes pending at edge n+S
      edg  = m_hist[S] & ~m_hist[S+1];
      elig = m_pend & mask;
      t    = top_of(elig);
      case (m_mode)
         M_IDLE: if (t >= 0) begin
            m_mode = M_REQ; m_w = t; m_pend[t] = 1'b0; m_cnt = 0;
         end
         M_REQ: if (exp_ack) begin
            m_mode = M_SERVE; m_cnt = 0;
         end else begin
            m_cnt++;
            if (m_cnt == TO) begin
               tmo = 1'b1; m_pend[m_w] = 1'b1; m_cnt = 0;
               if (m_stk.size() > 0) begin m_w = m_stk.pop_back(); m_mode = M_SERVE; end
               else m_mode = M_IDLE;
            end
         end
         default: begin
            if (eret) begin
               if (m_stk.size() > 0) m_w = m_stk.pop_back();
               else m_mode = M_IDLE;
            end
`ifdef EXC_ARBITER_NESTED_EN
            else if (t > m_w) begin
               m_stk.push_back(m_w); m_w = t; m_pend[t] = 1'b0; m_mode = M_REQ; m_cnt = 0;
            end
`endif
         end
      endcase
      m_pend = m_pend | edg;
      if (tmo) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
   endtask

   task automatic model_check();
      bit [2:0] e_req, e_svc;
      bit [1:0] e_cause;
      e_req   = (m_mode == M_REQ) ? oh(m_w) : 3'b000;
      e_svc   = (m_mode == M_SERVE) ? oh(m_w) :
                ((m_mode == M_REQ && m_stk.size() > 0) ? oh(m_stk[$]) : 3'b000);
      e_cause = (m_mode == M_IDLE) ? 2'd0 : 2'(m_w + 1);
      chk("model_cycle",
          32'({exp_req, pending, in_service, cause_id, busy, timeout_err}),
          32'({e_req, m_pend, e_svc, e_cause, (m_mode != M_IDLE), m_err}));
   endtask

   // model update on each rising edge, DUT compared 1 ns later
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!reset) model_reset();
         else model_step();
         #1;
         model_check();
      end
   end

   // ---------------- directed and random stimulus ----------------
   task automatic ack_eret();
      exp_ack = 1'b1; @(negedge clk); exp_ack = 1'b0;
      eret = 1'b1;    @(negedge clk); eret = 1'b0;
   endtask

   task automatic pulse_to_pending(input logic [2:0] v);
      irq_in = v; @(negedge clk); irq_in = 3'b000;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int hi;
      int seen;
      int idx;
      int ack_div;
      repeat (2) @(negedge clk);
      chk("reset_state", 32'({exp_req, pending, in_service, cause_id, busy, timeout_err}), 32'd0);
      reset = 1'b1;

      // reset in the middle of a request
      irq_in = 3'b001;
      repeat (3) @(negedge clk);
      chk("rst_pending", 32'(pending), 32'h1);
      @(negedge clk);
      chk("rst_req", 32'({exp_req, cause_id}), 32'({3'b001, 2'd1}));
      irq_in = 3'b000;
      #2 reset = 1'b0;
      #1 chk("async_reset", 32'({exp_req, pending, busy, cause_id}), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("after_release", 32'({busy, exp_req}), 32'd0);

      // single source
      pulse_to_pending(3'b010);
      chk("single_pending", 32'(pending), 32'h2);
      @(negedge clk);
      chk("single_req", 32'({exp_req, cause_id}), 32'({3'b010, 2'd2}));
      exp_ack = 1'b1; @(negedge clk); exp_ack = 1'b0;
      chk("single_serve", 32'({in_service, exp_req}), 32'({3'b010, 3'b000}));
      eret = 1'b1; @(negedge clk); eret = 1'b0;
      chk("single_done", 32'({in_service, busy}), 32'd0);

      // priority 2 > 1 > 0
      pulse_to_pending(3'b111);
      chk("prio_pending", 32'(pending), 32'h7);
      @(negedge clk);
      chk("prio_first", 32'({exp_req, cause_id, pending}), 32'({3'b100, 2'd3, 3'b011}));
      ack_eret(); @(negedge clk);
      chk("prio_second", 32'({exp_req, cause_id, pending}), 32'({3'b010, 2'd2, 3'b001}));
      ack_eret(); @(negedge clk);
      chk("prio_third", 32'({exp_req, cause_id, pending}), 32'({3'b001, 2'd1, 3'b000}));
      ack_eret(); @(negedge clk);
      chk("prio_idle", 32'(busy), 32'd0);

      // masked source stays pending
      mask = 3'b110;
      pulse_to_pending(3'b001);
      chk("mask_pending", 32'(pending), 32'h1);
      seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (exp_req != 3'b000) seen = 1;
      end
      chk("mask_no_req", 32'(seen), 32'd0);
      mask = 3'b111; @(negedge clk);
      chk("unmask_req", 32'({exp_req, cause_id}), 32'({3'b001, 2'd1}));
      ack_eret(); @(negedge clk);

      // request timeout
      pulse_to_pending(3'b100);
      @(negedge clk);
      hi = (exp_req == 3'b100) ? 1 : 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (exp_req == 3'b100) hi++;
         else break;
      end
      chk("timeout_len", 32'(hi), 32'(TO));
      chk("timeout_state", 32'({timeout_err, pending, busy, exp_req}), 32'({1'b1, 3'b100, 1'b0, 3'b000}));
      @(negedge clk);
      chk("timeout_rereq", 32'(exp_req), 32'h4);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      chk("err_clr", 32'(timeout_err), 32'd0);
      ack_eret(); @(negedge clk);

      // higher source arriving during a service
      pulse_to_pending(3'b001);
      @(negedge clk);
      exp_ack = 1'b1; @(negedge clk); exp_ack = 1'b0;
      chk("nest_base", 32'(in_service), 32'h1);
      pulse_to_pending(3'b100);
      chk("nest_pending", 32'(pending), 32'h4);
`ifdef EXC_ARBITER_NESTED_EN
      @(negedge clk);
      chk("nest_preempt", 32'({exp_req, in_service}), 32'({3'b100, 3'b001}));
      exp_ack = 1'b1; @(negedge clk); exp_ack = 1'b0;
      chk("nest_serve2", 32'({in_service, cause_id}), 32'({3'b100, 2'd3}));
      eret = 1'b1; @(negedge clk); eret = 1'b0;
      chk("nest_pop", 32'({in_service, cause_id, busy}), 32'({3'b001, 2'd1, 1'b1}));
      eret = 1'b1; @(negedge clk); eret = 1'b0;
      chk("nest_idle", 32'({in_service, busy}), 32'd0);
`else
      repeat (10) @(negedge clk);
      chk("nopre_wait", 32'({exp_req, in_service, pending}), 32'({3'b000, 3'b001, 3'b100}));
      eret = 1'b1; @(negedge clk); eret = 1'b0;
      chk("nopre_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("nopre_req2", 32'({exp_req, cause_id}), 32'({3'b100, 2'd3}));
      ack_eret();
`endif
      @(negedge clk);

      // randomized traffic, model checks every cycle
      for (int ph = 0; ph < 2; ph++) begin
         ack_div = (ph == 0) ? 4 : 20;
         repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
               idx = int'($urandom_range(0, 2));
               irq_in[idx] = ~irq_in[idx];
            end
            if ($urandom_range(0, 49) == 0) mask = 3'($urandom);
            exp_ack = ($urandom_range(0, ack_div - 1) == 0);
            eret    = ($urandom_range(0, 5) == 0);
            err_clr = ($urandom_range(0, 29) == 0);
         end
      end
      irq_in = 3'b000; exp_ack = 1'b0; eret = 1'b0; err_clr = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
